netwalk_action_mem_program_ctrl: RTL
====================================

Name: netwalk_action_mem_program_ctrl

Overview:
- Sequences all writes into the action-fetch unit's action memories (program, single delete, clear-all).
- The fetch unit ignores lookups in any cycle where exec_program_enable is high, so this block has two jobs:
  - Place each write in a lookup gap.
  - If no gap appears within a bounded time, stall the upstream lookup stream.
- Two requesters share the write port: the host configuration path and the flow-eviction path.

Parameters:
- ACTION_FLAG_WIDTH, 16, action flag field width.
- ACTION_SET_WIDTH, 356, action set field width.
- TCAM_ADDR_WIDTH, 6, action memory address width; memory depth = 1<<TCAM_ADDR_WIDTH.
- STARVE_LIMIT, 8, cycles a captured write may wait for a gap before a forced stall.
- STAT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- glbl_program_en  in  1  when high, a pending write issues immediately and lookup_stall is asserted.
- host_req_valid  in  1  host command valid.
- host_req_ready  out  1  host command accepted this cycle.
- host_req_delete  in  1  1 = delete entry, 0 = program entry.
- host_req_addr  in  TCAM_ADDR_WIDTH  target entry.
- host_req_data  in  ACTION_FLAG_WIDTH+ACTION_SET_WIDTH  {flag, set}.
- evict_req_valid  in  1  eviction delete valid.
- evict_req_ready  out  1  eviction accepted this cycle.
- evict_req_addr  in  TCAM_ADDR_WIDTH  entry to delete.
- clear_all_start  in  1  pulse: delete every entry.
- clear_all_busy  out  1  clear sweep in progress.
- clear_all_done  out  1  one-cycle pulse at sweep end.
- lookup_pending  in  1  upstream will present a lookup next cycle unless lookup_stall is high this cycle.
- lookup_stall  out  1  combinational; upstream must hold its lookup.
- exec_program_enable  out  1  write strobe to the fetch unit.
- exec_delete_enable  out  1  delete qualifier.
- exec_program_addr  out  TCAM_ADDR_WIDTH  write address.
- exec_program_data  out  ACTION_FLAG_WIDTH+ACTION_SET_WIDTH  write data.
- stat_writes  out  STAT_WIDTH  writes issued, saturating.
- stat_forced_stalls  out  STAT_WIDTH  forced stalls, saturating.

Behaviour:
- Reset: state IDLE, all exec_* outputs 0, ready/busy/done/stall 0, counters 0, pending-clear flag 0, rr pointer = host. Reset mid-sweep or mid-wait abandons the operation with no write issued.
- The exec_* outputs are registered and zero in every cycle except the single issue cycle. exec_program_enable is never high for two consecutive commands without returning to IDLE.
- IDLE:
  - If the pending-clear flag or clear_all_start is set -> CLEAR with sweep addr = 0.
  - Otherwise round-robin arbitration. If both requesters are valid, grant the one not granted last. If only one is valid, grant it.
  - Winner's ready = 1 combinationally in the same cycle. Capture {delete, addr, data}; eviction captures delete = 1, data = 0. Go to WAIT with starve count = 0.
  - Both ready signals are 0 in every state other than IDLE.
- WAIT (gap rule):
  - If lookup_pending = 0 or glbl_program_en = 1: register the write so it appears on exec_* in the next cycle; go to IDLE.
  - Else if starve count = STARVE_LIMIT-1: drive lookup_stall = 1 this cycle, issue the write the same way, increment stat_forced_stalls, go to IDLE.
  - Else: increment the starve count and stay in WAIT.
  - glbl_program_en = 1 in WAIT also asserts lookup_stall; it is not counted as a forced stall.
- Write latency: a write appears 1 cycle after the issue decision. The accept-to-write minimum is 2 cycles; the maximum is STARVE_LIMIT+1 cycles.
- CLEAR:
  - lookup_stall = 1 and clear_all_busy = 1 for the whole sweep.
  - Issue a delete each cycle to addresses 0 .. depth-1 in order: depth consecutive cycles with exec_program_enable = 1 and exec_delete_enable = 1.
  - After the last address: clear_all_done pulses for 1 cycle in the cycle after the last write, then return to IDLE.
- clear_all_start outside IDLE sets the pending-clear flag. The clear is served at the next IDLE with priority over both requesters. Multiple starts before service collapse into one sweep.
- stat_writes increments once per exec_program_enable cycle, including sweep deletes. Both stat counters saturate at all-ones.

Decomposition:
- Shared package netwalk_exec_pkg holds:
  - PROGRAM_DATA_WIDTH = ACTION_FLAG_WIDTH+ACTION_SET_WIDTH.
  - ACTION_MEM_SIZE = 1<<TCAM_ADDR_WIDTH.
  - State encodings IDLE/WAIT/CLEAR.
- One sub-module: netwalk_rr_arbiter2, a 2-requester round-robin arbiter with a grant-update strobe.

Test Plan:
- Host program, no lookups: addr=5, data={16'h00A3, set=356'h1F}, lookup_pending=0 -> ready in accept cycle; exec_program_enable=1, delete=0, addr=5 exactly 2 cycles later; stat_writes=1.
- Starvation: lookup_pending held 1, STARVE_LIMIT=8, host delete addr=9 -> lookup_stall high only in the 8th WAIT cycle; delete to 9 the next cycle; stat_forced_stalls=1.
- Contention: host (addr 3) and evict (addr 7) both valid continuously after reset -> grants alternate host, evict, host; evict writes carry data=0 and delete=1.
- Clear-all: pulse start with TCAM_ADDR_WIDTH=6 -> 64 consecutive delete cycles, addr 0..63; stall and busy high throughout; done pulse 1 cycle after addr 63; stat_writes=64.
- Start during WAIT: clear_all_start arrives while a host write waits -> host write issues first, then the sweep starts from IDLE; a second start mid-sweep triggers exactly one more sweep.
- Reset mid-sweep at addr 20 -> next cycle all outputs 0 and state IDLE; no further deletes; no done pulse.

Source files
------------

// File: rtl/netwalk_exec_pkg.sv
// netwalk_exec_pkg: shared widths, depth and controller state encoding for the action-memory write path
package netwalk_exec_pkg;
    localparam int ACTION_FLAG_W      = 16;
    localparam int ACTION_SET_W       = 356;
    localparam int TCAM_ADDR_W        = 6;
    localparam int PROGRAM_DATA_WIDTH = ACTION_FLAG_W + ACTION_SET_W;
    localparam int ACTION_MEM_SIZE    = 1 << TCAM_ADDR_W;
    typedef enum logic [1:0] {IDLE, WAIT, CLEAR} state_t;
endpackage

// File: rtl/netwalk_action_mem_program_ctrl_if.sv
// netwalk_action_mem_program_ctrl_if: host/evict request channels and the exec write port of the program controller
interface netwalk_action_mem_program_ctrl_if
    import netwalk_exec_pkg::*;
#(
    parameter int AW = TCAM_ADDR_W,
    parameter int DW = PROGRAM_DATA_WIDTH
);
    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_req_delete;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_data;
    logic          evict_req_valid;
    logic          evict_req_ready;
    logic [AW-1:0] evict_req_addr;
    logic          exec_program_enable;
    logic          exec_delete_enable;
    logic [AW-1:0] exec_program_addr;
    logic [DW-1:0] exec_program_data;
    modport master (
        output host_req_valid, host_req_delete, host_req_addr, host_req_data,
        output evict_req_valid, evict_req_addr,
        input  host_req_ready, evict_req_ready,
        input  exec_program_enable, exec_delete_enable, exec_program_addr, exec_program_data
    );
    modport slave (
        input  host_req_valid, host_req_delete, host_req_addr, host_req_data,
        input  evict_req_valid, evict_req_addr,
        output host_req_ready, evict_req_ready,
        output exec_program_enable, exec_delete_enable, exec_program_addr, exec_program_data
    );
endinterface

// File: rtl/netwalk_rr_arbiter2.sv
// netwalk_rr_arbiter2: two-requester round-robin arbiter; priority flips to the other side on each strobed grant
module netwalk_rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic prio_q, prio_d;
    assign gnt[0] = req[0] & (~req[1] | ~prio_q);
    assign gnt[1] = req[1] & (~req[0] | prio_q);
    always_comb prio_d = (update & |gnt) ? gnt[0] : prio_q;
    always_ff @(posedge clk) begin
        if (reset) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end
endmodule

// File: rtl/netwalk_action_mem_program_ctrl.sv
// netwalk_action_mem_program_ctrl: slots action-memory writes into lookup gaps, forcing a stall after a bounded wait
module netwalk_action_mem_program_ctrl
    import netwalk_exec_pkg::*;
#(
    parameter int ACTION_FLAG_WIDTH = ACTION_FLAG_W,
    parameter int ACTION_SET_WIDTH  = ACTION_SET_W,
    parameter int TCAM_ADDR_WIDTH   = TCAM_ADDR_W,
    parameter int STARVE_LIMIT      = 8,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  glbl_program_en,
    input  logic                  clear_all_start,
    output logic                  clear_all_busy,
    output logic                  clear_all_done,
    input  logic                  lookup_pending,
    output logic                  lookup_stall,
    output logic [STAT_WIDTH-1:0] stat_writes,
    output logic [STAT_WIDTH-1:0] stat_forced_stalls,
    netwalk_action_mem_program_ctrl_if.slave bus
);
    localparam int DW = ACTION_FLAG_WIDTH + ACTION_SET_WIDTH;
    localparam int AW = TCAM_ADDR_WIDTH;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_t                state_q, state_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  del_q, del_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         data_q, data_d;
    logic                  clr_pend_q, clr_pend_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  ex_en_q, ex_en_d;
    logic                  ex_del_q, ex_del_d;
    logic [AW-1:0]         ex_addr_q, ex_addr_d;
    logic [DW-1:0]         ex_data_q, ex_data_d;
    logic [STAT_WIDTH-1:0] wr_q, wr_d;
    logic [STAT_WIDTH-1:0] fs_q, fs_d;
    logic                  clr_go, issue, forced, stall;
    logic [1:0]            req, gnt;
    assign clr_go = (state_q == IDLE) & (clr_pend_q | clear_all_start);
    assign req    = {bus.evict_req_valid, bus.host_req_valid} & {2{(state_q == IDLE) & ~clr_go}};
    netwalk_rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (|gnt),
        .gnt    (gnt)
    );
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        del_d      = del_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = 1'b0;
        issue      = 1'b0;
        forced     = 1'b0;
        stall      = 1'b0;
        clr_pend_d = (state_q != IDLE) & (clr_pend_q | clear_all_start);
        case (state_q)
            IDLE: begin
                if (clr_go) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end else if (|gnt) begin
                    state_d  = WAIT;
                    starve_d = '0;
                    del_d    = gnt[1] | bus.host_req_delete;
                    addr_d   = gnt[1] ? bus.evict_req_addr : bus.host_req_addr;
                    data_d   = gnt[1] ? '0 : bus.host_req_data;
                end
            end
            WAIT: begin
                forced   = lookup_pending & ~glbl_program_en & (starve_q == SW'(STARVE_LIMIT - 1));
                stall    = glbl_program_en | forced;
                issue    = ~lookup_pending | glbl_program_en | forced;
                starve_d = starve_q + SW'(1);
                state_d  = issue ? IDLE : WAIT;
            end
            CLEAR: begin
                stall   = 1'b1;
                issue   = 1'b1;
                addr_d  = addr_q + AW'(1);
                last_d  = &addr_q;
                state_d = (&addr_q) ? IDLE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
        ex_en_d   = issue;
        ex_del_d  = issue & ((state_q == CLEAR) | del_q);
        ex_addr_d = issue ? addr_q : '0;
        ex_data_d = (issue & (state_q == WAIT)) ? data_q : '0;
        done_d    = last_q;
        wr_d      = (issue & ~&wr_q) ? wr_q + STAT_WIDTH'(1) : wr_q;
        fs_d      = (forced & ~&fs_q) ? fs_q + STAT_WIDTH'(1) : fs_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            del_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            clr_pend_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            ex_en_q    <= 1'b0;
            ex_del_q   <= 1'b0;
            ex_addr_q  <= '0;
            ex_data_q  <= '0;
            wr_q       <= '0;
            fs_q       <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            del_q      <= del_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            clr_pend_q <= clr_pend_d;
            last_q     <= last_d;
            done_q     <= done_d;
            ex_en_q    <= ex_en_d;
            ex_del_q   <= ex_del_d;
            ex_addr_q  <= ex_addr_d;
            ex_data_q  <= ex_data_d;
            wr_q       <= wr_d;
            fs_q       <= fs_d;
        end
    end
    assign bus.host_req_ready      = gnt[0];
    assign bus.evict_req_ready     = gnt[1];
    assign bus.exec_program_enable = ex_en_q;
    assign bus.exec_delete_enable  = ex_del_q;
    assign bus.exec_program_addr   = ex_addr_q;
    assign bus.exec_program_data   = ex_data_q;
    assign lookup_stall            = stall;
    assign clear_all_busy          = (state_q == CLEAR) | last_q;
    assign clear_all_done          = done_q;
    assign stat_writes             = wr_q;
    assign stat_forced_stalls      = fs_q;
endmodule
